// File: rtl/rsa_host_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_host_ctrl
//
// Host-side initiator for a wide-port RSA core. Collects p, q and the message
// as a stream of DW-bit words (LSW first: p words, then q words, then message
// words), presents them on the core's flat operand ports, sequences the core's
// two active-low resets (inverter first, then mod-exp), waits for the finish
// flag under a cycle timeout and streams the 2*WIDTH-bit result back out as
// DW-bit words (LSW first) with a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i, mode_i          launch a transaction (IDLE only); 1=encrypt
//   in_valid_i/in_ready_o    input word handshake, data on in_data_i
//   out_valid_o/out_ready_i  result word handshake, data on out_data_o,
//                            out_last_o marks the final word
//   busy_o                   high whenever a transaction is in flight
//   timeout_o                sticky, set when the core never finished
//   core_rst_n_o             core inverter reset (active-low)
//   core_rst1_n_o            core mod-exp reset (active-low)
//   core_encrypt_decrypt_o   latched mode
//   core_p_o/core_q_o        prime operands
//   core_msg_o               message operand
//   core_msg_i               core result
//   core_finish_i            core mod-exp finish flag
// ---------------------------------------------------------------------------
module rsa_host_ctrl #(
    parameter int WIDTH      = 1024,
    parameter int DW         = 32,
    parameter int RST_CYCLES = 2,
    parameter int INV_CYCLES = 4096,
    parameter int TIMEOUT    = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DW-1:0]      in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DW-1:0]      out_data_o,
    output logic               out_last_o,
    output logic               busy_o,
    output logic               timeout_o,
    output logic               core_rst_n_o,
    output logic               core_rst1_n_o,
    output logic               core_encrypt_decrypt_o,
    output logic [WIDTH-1:0]   core_p_o,
    output logic [WIDTH-1:0]   core_q_o,
    output logic [2*WIDTH-1:0] core_msg_o,
    input  logic [2*WIDTH-1:0] core_msg_i,
    input  logic               core_finish_i
);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int NP   = WIDTH / DW;        // words per prime
    localparam int NM   = 2 * NP;            // words per message / result
    localparam int NW   = 4 * NP;            // words per input transaction
    localparam int KW   = $clog2(NW);
    localparam int JW   = $clog2(NM);
    localparam int CMAX = max_int(max_int(RST_CYCLES, INV_CYCLES), TIMEOUT);
    localparam int CW   = $clog2(CMAX + 1);

    // Parameter sanity checks, reported at elaboration.
    if ((WIDTH % DW) != 0 || WIDTH < DW) begin : g_bad_width
        $error("rsa_host_ctrl: WIDTH must be a non-zero multiple of DW");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("rsa_host_ctrl: RST_CYCLES must be >= 1");
    end
    if (INV_CYCLES < 2) begin : g_bad_inv
        $error("rsa_host_ctrl: INV_CYCLES must be >= 2");
    end
    if (TIMEOUT < 2) begin : g_bad_tmo
        $error("rsa_host_ctrl: TIMEOUT must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_INV_RST  = 3'd2,
        S_INV_WAIT = 3'd3,
        S_EXP_RUN  = 3'd4,
        S_DRAIN    = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [KW-1:0]   k_r;
    logic [JW-1:0]   j_r;
    logic [JW-1:0]   j_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic            mode_r;
    logic            timeout_r;

    // Operand words: [0,NP) = p, [NP,2NP) = q, [2NP,4NP) = message.
    logic [DW-1:0]   op_r  [NW];
    // Result words; word 0 is always the one being presented.
    logic [DW-1:0]   res_r [NM];

    logic            in_ready_r;
    logic            out_valid_r;
    logic            out_last_r;
    logic            busy_r;
    logic            core_rst_n_r;
    logic            core_rst1_n_r;

    logic            in_ready_s;
    logic            out_valid_s;
    logic            out_last_s;
    logic            busy_s;
    logic            core_rst_n_s;
    logic            core_rst1_n_s;

    logic            start_acc_s;
    logic            in_hs_s;
    logic            load_last_s;
    logic            out_hs_s;
    logic            drain_last_s;
    logic            fin_ok_s;
    logic            tmo_s;

    assign start_acc_s  = (state_r == S_IDLE) && start_i;
    assign in_hs_s      = in_ready_r && in_valid_i;
    assign load_last_s  = in_hs_s && (k_r == KW'(NW - 1));
    assign out_hs_s     = out_valid_r && out_ready_i;
    assign drain_last_s = out_hs_s && (j_r == JW'(NM - 1));
    // A finish seen in the first EXP_RUN cycle may be left over from the
    // previous run, so it only counts once the counter has advanced.
    assign fin_ok_s     = (state_r == S_EXP_RUN) && core_finish_i && (cnt_r != {CW{1'b0}});
    assign tmo_s        = (state_r == S_EXP_RUN) && (cnt_r == CW'(TIMEOUT - 1));

    // State register plus the registered copies of all control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            j_r           <= {JW{1'b0}};
            cnt_r         <= {CW{1'b0}};
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            busy_r        <= 1'b0;
            core_rst_n_r  <= 1'b0;
            core_rst1_n_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            j_r           <= j_s;
            cnt_r         <= cnt_s;
            in_ready_r    <= in_ready_s;
            out_valid_r   <= out_valid_s;
            out_last_r    <= out_last_s;
            busy_r        <= busy_s;
            core_rst_n_r  <= core_rst_n_s;
            core_rst1_n_r <= core_rst1_n_s;
        end
    end

    // Next-state logic; finish takes priority over timeout in EXP_RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_i) state_s = S_LOAD;
                else         state_s = S_IDLE;
            end
            S_LOAD: begin
                if (load_last_s) state_s = S_INV_RST;
                else             state_s = S_LOAD;
            end
            S_INV_RST: begin
                if (cnt_r == CW'(RST_CYCLES - 1)) state_s = S_INV_WAIT;
                else                              state_s = S_INV_RST;
            end
            S_INV_WAIT: begin
                if (cnt_r == CW'(INV_CYCLES - 1)) state_s = S_EXP_RUN;
                else                              state_s = S_INV_WAIT;
            end
            S_EXP_RUN: begin
                if (fin_ok_s)   state_s = S_DRAIN;
                else if (tmo_s) state_s = S_IDLE;
                else            state_s = S_EXP_RUN;
            end
            S_DRAIN: begin
                if (drain_last_s) state_s = S_IDLE;
                else              state_s = S_DRAIN;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe.
    always_comb begin
        in_ready_s    = (state_s == S_LOAD);
        out_valid_s   = (state_s == S_DRAIN);
        busy_s        = (state_s != S_IDLE);
        core_rst_n_s  = (state_s inside {S_INV_WAIT, S_EXP_RUN, S_DRAIN});
        core_rst1_n_s = (state_s inside {S_EXP_RUN, S_DRAIN});

        if (fin_ok_s)      j_s = {JW{1'b0}};
        else if (out_hs_s) j_s = j_r + JW'(1);
        else               j_s = j_r;

        out_last_s = (state_s == S_DRAIN) && (j_s == JW'(NM - 1));

        // Cycle counter restarts on every state change.
        if (state_s != state_r)
            cnt_s = {CW{1'b0}};
        else if (state_r inside {S_INV_RST, S_INV_WAIT, S_EXP_RUN})
            cnt_s = cnt_r + CW'(1);
        else
            cnt_s = {CW{1'b0}};
    end

    // Datapath: mode/timeout flags, input word capture, result shift-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_r       <= {KW{1'b0}};
            mode_r    <= 1'b0;
            timeout_r <= 1'b0;
            for (int w = 0; w < NW; w++) op_r[w]  <= {DW{1'b0}};
            for (int m = 0; m < NM; m++) res_r[m] <= {DW{1'b0}};
        end else begin
            if (start_acc_s) begin
                mode_r    <= mode_i;
                timeout_r <= 1'b0;
            end else if (tmo_s && !fin_ok_s) begin
                timeout_r <= 1'b1;
            end

            if (start_acc_s)  k_r <= {KW{1'b0}};
            else if (in_hs_s) k_r <= k_r + KW'(1);

            for (int w = 0; w < NW; w++) begin
                if (in_hs_s && (k_r == KW'(w))) op_r[w] <= in_data_i;
            end

            if (fin_ok_s) begin
                for (int m = 0; m < NM; m++) res_r[m] <= core_msg_i[m*DW +: DW];
            end else if (out_hs_s) begin
                for (int m = 0; m < NM - 1; m++) res_r[m] <= res_r[m+1];
                res_r[NM-1] <= {DW{1'b0}};
            end
        end
    end

    for (genvar w = 0; w < NP; w++) begin : g_pq
        assign core_p_o[w*DW +: DW] = op_r[w];
        assign core_q_o[w*DW +: DW] = op_r[NP + w];
    end
    for (genvar m = 0; m < NM; m++) begin : g_msg
        assign core_msg_o[m*DW +: DW] = op_r[2*NP + m];
    end

    assign in_ready_o             = in_ready_r;
    assign out_valid_o            = out_valid_r;
    assign out_last_o             = out_last_r;
    assign out_data_o             = res_r[0];
    assign busy_o                 = busy_r;
    assign timeout_o              = timeout_r;
    assign core_rst_n_o           = core_rst_n_r;
    assign core_rst1_n_o          = core_rst1_n_r;
    assign core_encrypt_decrypt_o = mode_r;

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Testbench for rsa_host_ctrl: behavioural RSA core model, scoreboard of
// expected result words, and a decoupled output monitor.
module tb_rsa_host_ctrl;

    localparam int WIDTH      = 64;
    localparam int DW         = 32;
    localparam int RST_CYCLES = 2;
    localparam int INV_CYCLES = 8;
    localparam int TIMEOUT    = 50;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic               mode_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [DW-1:0]      in_data_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DW-1:0]      out_data_o;
    logic               out_last_o;
    logic               busy_o;
    logic               timeout_o;
    logic               core_rst_n_o;
    logic               core_rst1_n_o;
    logic               core_encrypt_decrypt_o;
    logic [WIDTH-1:0]   core_p_o;
    logic [WIDTH-1:0]   core_q_o;
    logic [2*WIDTH-1:0] core_msg_o;
    logic [2*WIDTH-1:0] core_msg_i;
    logic               core_finish_i;

    rsa_host_ctrl #(
        .WIDTH(WIDTH), .DW(DW), .RST_CYCLES(RST_CYCLES),
        .INV_CYCLES(INV_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .busy_o(busy_o), .timeout_o(timeout_o),
        .core_rst_n_o(core_rst_n_o), .core_rst1_n_o(core_rst1_n_o),
        .core_encrypt_decrypt_o(core_encrypt_decrypt_o),
        .core_p_o(core_p_o), .core_q_o(core_q_o), .core_msg_o(core_msg_o),
        .core_msg_i(core_msg_i), .core_finish_i(core_finish_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_data_q[$];
    bit          exp_last_q[$];

    int in_hs  = 0;
    int out_hs = 0;
    int rdy_mode = 0;
    bit stale_req = 1'b0;
    bit no_finish = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // msg^e mod n by square-and-multiply on wide integers.
    function automatic logic [127:0] modexp(input logic [127:0] b, input logic [31:0] e,
                                            input logic [127:0] n);
        logic [255:0] r, x, nn;
        nn = {128'd0, n};
        r  = 256'd1 % nn;
        x  = {128'd0, b} % nn;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[127:0];
    endfunction

    // Behavioural RSA core: finish rises 10 cycles after the mod-exp reset
    // is released, optionally preceded by a stale finish pulse with junk data.
    initial begin
        int run_cyc;
        logic [127:0] nmod;
        run_cyc       = 0;
        core_finish_i = 1'b0;
        core_msg_i    = 128'd0;
        forever begin
            tick();
            if (!core_rst1_n_o) begin
                run_cyc       = 0;
                core_finish_i = 1'b0;
            end else begin
                run_cyc++;
                if (run_cyc == 1 && stale_req) begin
                    core_finish_i = 1'b1;
                    core_msg_i    = {$urandom, $urandom, $urandom, $urandom};
                end else if (run_cyc >= 10 && !no_finish) begin
                    nmod          = {64'd0, core_p_o} * {64'd0, core_q_o};
                    core_finish_i = 1'b1;
                    core_msg_i    = modexp(core_msg_o,
                                           core_encrypt_decrypt_o ? 32'd17 : 32'd2753, nmod);
                end else begin
                    core_finish_i = 1'b0;
                end
            end
        end
    end

    // Output-ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        int idx;
        idx         = 0;
        out_ready_i = 1'b1;
        forever begin
            tick();
            case (rdy_mode)
                1:       out_ready_i = ((idx % 4) == 0) || ((idx % 4) == 3);
                2:       out_ready_i = 1'($urandom_range(0, 1));
                default: out_ready_i = 1'b1;
            endcase
            idx++;
        end
    end

    // Monitor: counts handshakes, pops the scoreboard on every output
    // handshake and checks stability of stalled output words.
    initial begin
        bit          stall_p;
        logic [31:0] held_d;
        logic        held_l;
        logic [31:0] ed;
        bit          el;
        stall_p = 1'b0;
        held_d  = 32'd0;
        held_l  = 1'b0;
        forever begin
            @(negedge clk);
            if (in_valid_i && in_ready_o) in_hs++;
            if (out_valid_o) begin
                if (stall_p) begin
                    check("stall_data", out_data_o, held_d);
                    check("stall_last", out_last_o, held_l);
                end
                if (out_ready_i) begin
                    out_hs++;
                    stall_p = 1'b0;
                    if (exp_data_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got data %0h with no expected word queued",
                                 out_data_o);
                    end else begin
                        ed = exp_data_q.pop_front();
                        el = exp_last_q.pop_front();
                        check("out_data", out_data_o, ed);
                        check("out_last", out_last_o, el);
                        if (el) begin
                            tick();
                            check("busy_after_last", busy_o, 1'b0);
                            check("valid_after_last", out_valid_o, 1'b0);
                        end
                    end
                end else begin
                    stall_p = 1'b1;
                    held_d  = out_data_o;
                    held_l  = out_last_o;
                end
            end else begin
                if (stall_p) check("valid_held_in_stall", out_valid_o, 1'b1);
                stall_p = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_state();
        check("rst_ctrl", {in_ready_o, out_valid_o, out_last_o, busy_o, timeout_o,
                           core_encrypt_decrypt_o, core_rst_n_o, core_rst1_n_o}, 8'd0);
        check("rst_data", out_data_o, 32'd0);
        check("rst_pq", {core_p_o, core_q_o}, 128'd0);
        check("rst_msg", core_msg_o, 128'd0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) tick();
        end
        in_valid_i = 1'b1;
        in_data_i  = w;
        n = 0;
        while (!in_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("in_ready_wait", in_ready_o, 1'b1);
        tick();
        in_valid_i = 1'b0;
        in_data_i  = $urandom;
    endtask

    task automatic run_txn(input bit mode, input logic [63:0] p, input logic [63:0] q,
                           input logic [127:0] msg, input logic [127:0] exp_res,
                           input bit gaps, input bit nofin, input bit stale, input bit sie);
        logic [31:0] words [8];
        int  n, m;
        bit  mode_bad;
        words[0] = p[31:0];    words[1] = p[63:32];
        words[2] = q[31:0];    words[3] = q[63:32];
        words[4] = msg[31:0];  words[5] = msg[63:32];
        words[6] = msg[95:64]; words[7] = msg[127:96];
        in_hs     = 0;
        out_hs    = 0;
        no_finish = nofin;
        stale_req = stale;
        if (!nofin) begin
            for (int i = 0; i < 4; i++) begin
                exp_data_q.push_back(exp_res[i*32 +: 32]);
                exp_last_q.push_back(i == 3);
            end
        end

        start_i = 1'b1;
        mode_i  = mode;
        tick();
        start_i = 1'b0;
        mode_i  = 1'($urandom);
        check("start_busy", busy_o, 1'b1);
        check("start_ready", in_ready_o, 1'b1);
        check("start_timeout_clr", timeout_o, 1'b0);
        check("start_mode", core_encrypt_decrypt_o, mode);

        for (int i = 0; i < 8; i++) send_word(words[i], gaps);
        check("in_ready_drop", in_ready_o, 1'b0);

        n = 0;
        while (!core_rst_n_o && n < 100) begin
            n++;
            tick();
        end
        check("inv_rst_len", n, RST_CYCLES);
        m = 0;
        while (!core_rst1_n_o && m < 100) begin
            m++;
            tick();
        end
        check("inv_wait_len", m, INV_CYCLES);

        if (sie) begin
            start_i = 1'b1;
            mode_i  = ~mode;
            tick();
            start_i = 1'b0;
            check("start_in_exp_ready", in_ready_o, 1'b0);
            check("start_in_exp_mode", core_encrypt_decrypt_o, mode);
        end

        if (nofin) begin
            n = 0;
            while (!timeout_o && n < 200) begin
                tick();
                n++;
            end
            check("timeout_delay", n, TIMEOUT);
            check("timeout_busy", busy_o, 1'b0);
            check("timeout_core_rst", {core_rst_n_o, core_rst1_n_o}, 2'b00);
            check("timeout_no_output", out_hs, 0);
        end else begin
            mode_bad = 1'b0;
            n = 0;
            while (busy_o && n < 300) begin
                if (core_encrypt_decrypt_o !== mode) mode_bad = 1'b1;
                tick();
                n++;
            end
            check("drain_done", busy_o, 1'b0);
            check("mode_held", mode_bad, 1'b0);
            check("out_handshakes", out_hs, 4);
            check("scoreboard_empty", exp_data_q.size(), 0);
        end
        check("in_handshakes", in_hs, 8);
        stale_req = 1'b0;
        no_finish = 1'b0;
    endtask

    initial begin
        logic [63:0]  rp, rq;
        logic [127:0] rmsg;
        bit           rmode;
        rst        = 1'b1;
        start_i    = 1'b0;
        mode_i     = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = 32'd0;
        tick();
        tick();
        check_reset_state();
        rst = 1'b0;
        tick();

        // 1: encrypt 65 with p=61, q=53
        run_txn(1'b1, 64'd61, 64'd53, 128'd65, 128'd2790, 1'b0, 1'b0, 1'b0, 1'b0);
        // 2: decrypt back
        run_txn(1'b0, 64'd61, 64'd53, 128'd2790, 128'd65, 1'b0, 1'b0, 1'b0, 1'b0);
        // 3: input gaps and output backpressure 1,0,0,1
        rdy_mode = 1;
        run_txn(1'b1, 64'd61, 64'd53, 128'd65, 128'd2790, 1'b1, 1'b0, 1'b0, 1'b0);
        rdy_mode = 0;
        // 4: timeout, sticky flag, then a normal transaction
        run_txn(1'b1, 64'd61, 64'd53, 128'd65, 128'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check("timeout_sticky", timeout_o, 1'b1);
        run_txn(1'b1, 64'd61, 64'd53, 128'd65, 128'd2790, 1'b0, 1'b0, 1'b0, 1'b0);
        // 5: reset after three input words
        start_i = 1'b1;
        mode_i  = 1'b1;
        tick();
        start_i = 1'b0;
        send_word(32'd61, 1'b0);
        send_word(32'd0, 1'b0);
        send_word(32'd53, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state();
        run_txn(1'b1, 64'd61, 64'd53, 128'd65, 128'd2790, 1'b0, 1'b0, 1'b0, 1'b0);
        // 6: stale finish pulse and start during EXP_RUN
        run_txn(1'b1, 64'd61, 64'd53, 128'd65, 128'd2790, 1'b0, 1'b0, 1'b1, 1'b1);
        run_txn(1'b0, 64'd61, 64'd53, 128'd2790, 128'd65, 1'b1, 1'b0, 1'b1, 1'b0);

        // Randomized operands, modes and handshakes
        rdy_mode = 2;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                rp   = {64{1'b1}};
                rq   = {64{1'b1}};
                rmsg = {128{1'b1}};
            end else begin
                rp   = {$urandom, $urandom};
                rq   = {$urandom, $urandom};
                rmsg = {$urandom, $urandom, $urandom, $urandom};
                rp[0] = 1'b1;
                rq[0] = 1'b1;
            end
            rmode = 1'($urandom_range(0, 1));
            run_txn(rmode, rp, rq, rmsg,
                    modexp(rmsg, rmode ? 32'd17 : 32'd2753, {64'd0, rp} * {64'd0, rq}),
                    1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        rdy_mode = 0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_host_ctrl.md
Name: rsa_host_ctrl

Overview:
- Host-side initiator for the RSA core. The RSA core has wide flat operand ports, active-low resets and a finish flag.
- This block accepts p, q and message as a DW-bit word stream, then drives the core's operands and mode.
- It sequences the core's inverter reset and mod-exp reset, and waits for the finish flag with a timeout.
- It returns the 2*WIDTH-bit result as a DW-bit word stream with valid/ready handshake.

Parameters:
- WIDTH, 1024, prime width; core modulus/message width is 2*WIDTH.
- DW, 32, host word width. WIDTH must be a multiple of DW; elaborate-time error otherwise.
- RST_CYCLES, 2, cycles both core resets are held low at launch (>=1).
- INV_CYCLES, 4096, cycles the inverter runs before the mod-exp reset is released (>=2).
- TIMEOUT, 1000000, maximum cycles in EXP_RUN waiting for finish.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin transaction. Sampled only in IDLE.
- mode_i  in  1  1=encrypt, 0=decrypt. Latched when start_i is accepted.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  input word accepted when in_valid_i&in_ready_o.
- in_data_i  in  DW  input word.
- out_valid_o  out  1  result word valid.
- out_ready_i  in  1  result word consumed when out_valid_o&out_ready_i.
- out_data_o  out  DW  result word.
- out_last_o  out  1  marks the final result word.
- busy_o  out  1  high in any state except IDLE.
- timeout_o  out  1  sticky; set when the core did not finish in time.
- core_rst_n_o  out  1  core inverter reset, active-low.
- core_rst1_n_o  out  1  core mod-exp reset, active-low.
- core_encrypt_decrypt_o  out  1  latched mode.
- core_p_o  out  WIDTH  prime p register.
- core_q_o  out  WIDTH  prime q register.
- core_msg_o  out  2*WIDTH  message register.
- core_msg_i  in  2*WIDTH  core result.
- core_finish_i  in  1  core mod-exp finish.

Behaviour:
- Constants: NP=WIDTH/DW, NM=2*WIDTH/DW. Input transaction is 4*NP words; output transaction is NM words. All words are LSW first.
- Reset (rst=1 at a clk edge), outputs:
  - in_ready_o, out_valid_o, out_last_o, out_data_o, busy_o, timeout_o, core_encrypt_decrypt_o: 0.
  - core_rst_n_o, core_rst1_n_o: 0.
  - core_p_o, core_q_o, core_msg_o, result register: 0.
  - State goes to IDLE. Reset mid-transaction abandons it with no partial output.
- IDLE:
  - Both core resets held low.
  - start_i=1 → LOAD: latch mode_i, clear word counter k, clear timeout_o.
  - start_i in any other state is ignored.
- LOAD:
  - Both core resets held low; in_ready_o=1.
  - On each handshake, word k is written:
    - into p[k] for k<NP;
    - into q[k-NP] for NP<=k<2NP;
    - into msg[k-2NP] otherwise.
  - k increments on each handshake. The handshake with k=4NP-1 → INV_RST. in_ready_o drops the next cycle.
- INV_RST: both core resets low for exactly RST_CYCLES cycles → INV_WAIT.
- INV_WAIT: core_rst_n_o=1, core_rst1_n_o=0 for exactly INV_CYCLES cycles. This lets the core register its operands and exponent. → EXP_RUN.
- EXP_RUN:
  - core_rst1_n_o=1; cycle counter starts at 0.
  - core_finish_i is ignored in the first EXP_RUN cycle, to mask a stale finish.
  - From the second EXP_RUN cycle, core_finish_i=1 → capture core_msg_i into the result register → DRAIN.
  - If the counter reaches TIMEOUT with no finish: timeout_o=1, → IDLE. Both core resets are then low again.
  - If finish and timeout occur in the same cycle, finish wins.
- DRAIN:
  - Core resets are held at their EXP_RUN values.
  - out_valid_o=1, out_data_o=result word j (j=0..NM-1); out_last_o=1 when j=NM-1.
  - out_data_o and out_last_o are held stable while out_valid_o&!out_ready_i.
  - The handshake on j=NM-1 → IDLE; out_valid_o drops the next cycle.
- Core operand outputs are driven continuously from internal registers and change only in LOAD.
- timeout_o stays set until the next accepted start_i or rst.

Test Plan (WIDTH=64, DW=32, RST_CYCLES=2, INV_CYCLES=8, TIMEOUT=50; behavioural core model, finish 10 cycles after core_rst1_n_o rises; result = msg^(mode?17:2753) mod p*q):
1. Encrypt: start mode=1, then words 61,0,53,0,65,0,0,0 → out words 2790,0,0,0; out_last_o on 4th word only; busy_o=0 the cycle after the last handshake.
2. Decrypt: mode=0, msg 2790 → out words 65,0,0,0; core_encrypt_decrypt_o=0 from start to end.
3. Backpressure: random in_valid_i gaps and out_ready_i toggling 1,0,0,1 → exactly 8 input and 4 output handshakes; out_data_o stable across every stalled cycle; same result as test 1.
4. Timeout: model never asserts finish → timeout_o=1 exactly 50 cycles after EXP_RUN entry; out_valid_o stays 0; both core resets low. The next start clears timeout_o, and a normal transaction then completes.
5. Reset mid-LOAD after 3 words: rst for one cycle → all outputs at reset values. A following full encrypt transaction yields 2790,0,0,0.
6. Sequencing: after the last input word:
   - core_rst_n_o is low for exactly 2 cycles;
   - core_rst1_n_o is low for a further 8 cycles;
   - a finish pulse in the first EXP_RUN cycle is ignored;
   - start_i asserted during EXP_RUN has no effect.
